// File: rtl/bids22_ctrl_responder_if.sv
// bids22 control port bundle: host-driven op/start, responder-driven
// status and configuration outputs.
interface bids22_ctrl_responder_if #(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 3
);
    logic [DATAWIDTH-1:0]            C_data;
    logic [3:0]                      C_op;
    logic                            C_start;
    logic                            ready;
    logic [2:0]                      err;
    logic                            roundOver;
    logic                            roundActive;
    logic [2:0]                      state;
    logic [NUMBIDDERS*DATAWIDTH-1:0] bidderValue;
    logic [NUMBIDDERS-1:0]           mask;
    logic [DATAWIDTH-1:0]            timer;
    logic [DATAWIDTH-1:0]            bidCharge;

    modport master (
        output C_data, C_op, C_start,
        input  ready, err, roundOver, roundActive, state,
        input  bidderValue, mask, timer, bidCharge
    );

    modport slave (
        input  C_data, C_op, C_start,
        output ready, err, roundOver, roundActive, state,
        output bidderValue, mask, timer, bidCharge
    );
endinterface

// File: rtl/bids22_ctrl_responder.sv
// bids22 control responder: lock FSM, configuration registers and
// round sequencing for the bid arbitration datapath.
module bids22_ctrl_responder #(
    parameter int DATAWIDTH       = 32,
    parameter int NUMBIDDERS      = 3,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int TIMER_RESET     = 15
) (
    input  logic clk,
    input  logic reset_n,
    bids22_ctrl_responder_if.slave bus
);
    localparam int DW = DATAWIDTH;
    localparam int VW = NUMBIDDERS * DATAWIDTH;

    localparam logic [2:0] S_RESET        = 3'd0;
    localparam logic [2:0] S_UNLOCKED     = 3'd1;
    localparam logic [2:0] S_COOLDOWN     = 3'd2;
    localparam logic [2:0] S_LOCKED       = 3'd3;
    localparam logic [2:0] S_ROUNDSTARTED = 3'd4;
    localparam logic [2:0] S_ROUNDOVER    = 3'd5;
    localparam logic [2:0] S_READYNEXT    = 3'd6;

    localparam logic [3:0] OP_NOOP      = 4'd0;
    localparam logic [3:0] OP_UNLOCK    = 4'd1;
    localparam logic [3:0] OP_LOCK      = 4'd2;
    localparam logic [3:0] OP_LOADX     = 4'd3;
    localparam logic [3:0] OP_LOADY     = 4'd4;
    localparam logic [3:0] OP_LOADZ     = 4'd5;
    localparam logic [3:0] OP_SETMASK   = 4'd6;
    localparam logic [3:0] OP_SETTIMER  = 4'd7;
    localparam logic [3:0] OP_SETCHARGE = 4'd8;

    localparam logic [2:0] E_NOERROR   = 3'd0;
    localparam logic [2:0] E_BADKEY    = 3'd1;
    localparam logic [2:0] E_ALREADY   = 3'd2;
    localparam logic [2:0] E_CSTART    = 3'd3;
    localparam logic [2:0] E_INVALIDOP = 3'd4;

    localparam logic [DW-1:0] CNT_ONE  = DW'(1);
    localparam logic [DW-1:0] COOL_END = DW'(COOLDOWN_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [2:0]            err_q, err_d;
    logic [VW-1:0]         vals_q, vals_d;
    logic [NUMBIDDERS-1:0] mask_q, mask_d;
    logic [DW-1:0]         timer_q, timer_d;
    logic [DW-1:0]         charge_q, charge_d;
    logic [DW-1:0]         key_q, key_d;
    logic [DW-1:0]         cnt_q, cnt_d;
    logic                  cstart_q;

    logic [3:0]    op;
    logic [DW-1:0] data;
    logic          start;
    logic          start_rise;

    assign op         = bus.C_op;
    assign data       = bus.C_data;
    assign start      = bus.C_start;
    assign start_rise = start && !cstart_q;

    // Next-state, error code and configuration register updates.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        vals_d   = vals_q;
        mask_d   = mask_q;
        timer_d  = timer_q;
        charge_d = charge_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_RESET: begin
                state_d = S_UNLOCKED;
            end
            S_UNLOCKED: begin
                if (op != OP_NOOP) begin
                    err_d = E_NOERROR;
                    case (op)
                        OP_UNLOCK: err_d = E_ALREADY;
                        OP_LOCK: begin
                            key_d   = data;
                            state_d = S_LOCKED;
                        end
                        OP_LOADX, OP_LOADY, OP_LOADZ: begin
                            for (int i = 0; i < NUMBIDDERS; i++) begin
                                if (i < 3 && op == OP_LOADX + 4'(i)) begin
                                    vals_d[i*DW +: DW] = data;
                                end
                            end
                        end
                        OP_SETMASK: mask_d = data[NUMBIDDERS-1:0];
                        OP_SETTIMER: begin
                            timer_d = (data == '0) ? CNT_ONE : data;
                        end
                        OP_SETCHARGE: charge_d = data;
                        default: err_d = E_INVALIDOP;
                    endcase
                end else if (start) begin
                    err_d = E_CSTART;
                end
            end
            S_LOCKED: begin
                if (op == OP_UNLOCK) begin
                    if (data == key_q) begin
                        err_d   = E_NOERROR;
                        state_d = S_UNLOCKED;
                    end else begin
                        err_d   = E_BADKEY;
                        state_d = S_COOLDOWN;
                        cnt_d   = '0;
                    end
                end else if (op != OP_NOOP) begin
                    err_d = E_INVALIDOP;
                end else if (start_rise) begin
                    state_d = S_ROUNDSTARTED;
                    cnt_d   = '0;
                end
            end
            S_COOLDOWN: begin
                if (cnt_q == COOL_END) begin
                    state_d = S_LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ROUNDSTARTED: begin
                cnt_d = cnt_q + CNT_ONE;
                if (!start || (cnt_q + CNT_ONE == timer_q)) begin
                    state_d = S_ROUNDOVER;
                end
            end
            S_ROUNDOVER: begin
                state_d = S_READYNEXT;
            end
            S_READYNEXT: begin
                state_d = S_LOCKED;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // State and configuration registers with async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_RESET;
            err_q    <= E_NOERROR;
            vals_q   <= '0;
            mask_q   <= '1;
            timer_q  <= DW'(TIMER_RESET);
            charge_q <= CNT_ONE;
            key_q    <= '0;
            cnt_q    <= '0;
            cstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            vals_q   <= vals_d;
            mask_q   <= mask_d;
            timer_q  <= timer_d;
            charge_q <= charge_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            cstart_q <= start;
        end
    end

    // Status decode straight from the registered state.
    always_comb begin
        bus.ready       = (state_q == S_UNLOCKED) || (state_q == S_LOCKED);
        bus.roundActive = (state_q == S_ROUNDSTARTED);
        bus.roundOver   = (state_q == S_ROUNDOVER);
        bus.state       = state_q;
        bus.err         = err_q;
        bus.bidderValue = vals_q;
        bus.mask        = mask_q;
        bus.timer       = timer_q;
        bus.bidCharge   = charge_q;
    end
endmodule

// File: tb/tb_bids22_ctrl_responder.sv
// Directed bench for bids22_ctrl_responder: lock FSM, config writes,
// cooldown, round sequencing, timer expiry and async reset.
module tb_bids22_ctrl_responder;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    bids22_ctrl_responder_if bus ();

    bids22_ctrl_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_op(input logic [3:0] o, input logic [31:0] d);
        @(negedge clk);
        bus.C_op   = o;
        bus.C_data = d;
        @(negedge clk);
        bus.C_op   = 4'd0;
        bus.C_data = 32'd0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.C_op    = 4'd0;
        bus.C_data  = 32'd0;
        bus.C_start = 1'b0;
        #12;
        total++;
        if (bus.state !== 3'd0 || bus.ready !== 1'b0) begin
            $display("FAIL rst_state: state=%0d ready=%0b need 0/0",
                     bus.state, bus.ready);
            bad++;
        end
        total++;
        if (bus.err !== 3'd0 || bus.roundOver !== 1'b0 ||
            bus.roundActive !== 1'b0) begin
            $display("FAIL rst_flags: err=%0d ro=%0b ra=%0b need 0",
                     bus.err, bus.roundOver, bus.roundActive);
            bad++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.state !== 3'd1 || bus.ready !== 1'b1) begin
            $display("FAIL rel_state: state=%0d ready=%0b need 1/1",
                     bus.state, bus.ready);
            bad++;
        end
        total++;
        if (bus.timer !== 32'd15 || bus.bidCharge !== 32'd1 ||
            bus.mask !== 3'b111 || bus.bidderValue !== 96'd0) begin
            $display("FAIL rel_cfg: t=%0d c=%0d m=%b need 15/1/111",
                     bus.timer, bus.bidCharge, bus.mask);
            bad++;
        end
    endtask

    task automatic test_load();
        logic [3:0]  ops [4];
        logic [31:0] dat [4];
        ops = '{4'd3, 4'd4, 4'd5, 4'd6};
        dat = '{32'd45, 32'd46, 32'd47, 32'd5};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], dat[i]);
            total++;
            if (bus.err !== 3'd0) begin
                $display("FAIL load_err%0d: err=%0d need 0", i, bus.err);
                bad++;
            end
        end
        total++;
        if (bus.bidderValue[31:0] !== 32'd45 ||
            bus.bidderValue[63:32] !== 32'd46 ||
            bus.bidderValue[95:64] !== 32'd47) begin
            $display("FAIL load_vals: got %h need 2f/2e/2d",
                     bus.bidderValue);
            bad++;
        end
        total++;
        if (bus.mask !== 3'b101) begin
            $display("FAIL load_mask: got %b need 101", bus.mask);
            bad++;
        end
    endtask

    task automatic test_lock_unlock();
        do_op(4'd2, 32'd12);
        total++;
        if (bus.state !== 3'd3 || bus.ready !== 1'b1) begin
            $display("FAIL lock: state=%0d ready=%0b need 3/1",
                     bus.state, bus.ready);
            bad++;
        end
        do_op(4'd1, 32'd12);
        total++;
        if (bus.state !== 3'd1 || bus.err !== 3'd0) begin
            $display("FAIL unlock: state=%0d err=%0d need 1/0",
                     bus.state, bus.err);
            bad++;
        end
        do_op(4'd1, 32'd12);
        total++;
        if (bus.state !== 3'd1 || bus.err !== 3'd2) begin
            $display("FAIL already: state=%0d err=%0d need 1/2",
                     bus.state, bus.err);
            bad++;
        end
    endtask

    task automatic test_badkey();
        do_op(4'd2, 32'd12);
        do_op(4'd1, 32'd13);
        total++;
        if (bus.state !== 3'd2 || bus.err !== 3'd1) begin
            $display("FAIL badkey: state=%0d err=%0d need 2/1",
                     bus.state, bus.err);
            bad++;
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.ready !== 1'b0 || bus.state !== 3'd2) begin
                $display("FAIL cool%0d: ready=%0b state=%0d need 0/2",
                         i, bus.ready, bus.state);
                bad++;
            end
            bus.C_op   = (i < 4) ? 4'd1 : 4'd0;
            bus.C_data = 32'd12;
            @(negedge clk);
        end
        bus.C_data = 32'd0;
        total++;
        if (bus.ready !== 1'b1 || bus.state !== 3'd3 ||
            bus.err !== 3'd1) begin
            $display("FAIL cool_end: ready=%0b st=%0d err=%0d need 1/3/1",
                     bus.ready, bus.state, bus.err);
            bad++;
        end
        do_op(4'd1, 32'd12);
        total++;
        if (bus.state !== 3'd1 || bus.err !== 3'd0) begin
            $display("FAIL relock: state=%0d err=%0d need 1/0",
                     bus.state, bus.err);
            bad++;
        end
    endtask

    task automatic test_round();
        do_op(4'd2, 32'd12);
        @(negedge clk);
        bus.C_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.state !== 3'd4 || bus.roundActive !== 1'b1) begin
                $display("FAIL round%0d: state=%0d ra=%0b need 4/1",
                         i, bus.state, bus.roundActive);
                bad++;
            end
        end
        bus.C_start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.state !== 3'd5 || bus.roundOver !== 1'b1 ||
            bus.roundActive !== 1'b0) begin
            $display("FAIL rover: state=%0d ro=%0b ra=%0b need 5/1/0",
                     bus.state, bus.roundOver, bus.roundActive);
            bad++;
        end
        @(negedge clk);
        total++;
        if (bus.state !== 3'd6 || bus.roundOver !== 1'b0) begin
            $display("FAIL rnext: state=%0d ro=%0b need 6/0",
                     bus.state, bus.roundOver);
            bad++;
        end
        @(negedge clk);
        total++;
        if (bus.state !== 3'd3 || bus.ready !== 1'b1) begin
            $display("FAIL rlocked: state=%0d ready=%0b need 3/1",
                     bus.state, bus.ready);
            bad++;
        end
    endtask

    task automatic test_timer_expiry();
        logic [2:0] exp_st [10];
        exp_st = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd5,
                   3'd6, 3'd3, 3'd3, 3'd3, 3'd3};
        do_op(4'd1, 32'd12);
        do_op(4'd7, 32'd4);
        total++;
        if (bus.timer !== 32'd4) begin
            $display("FAIL settimer: got %0d need 4", bus.timer);
            bad++;
        end
        do_op(4'd2, 32'd12);
        @(negedge clk);
        bus.C_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.state !== exp_st[i]) begin
                $display("FAIL expire%0d: state=%0d need %0d",
                         i, bus.state, exp_st[i]);
                bad++;
            end
        end
        bus.C_start = 1'b0;
        @(negedge clk);
        bus.C_start = 1'b1;
        @(negedge clk);
        total++;
        if (bus.state !== 3'd4) begin
            $display("FAIL restart: state=%0d need 4", bus.state);
            bad++;
        end
        bus.C_start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.state !== 3'd3) begin
            $display("FAIL restart_end: state=%0d need 3", bus.state);
            bad++;
        end
    endtask

    task automatic test_cstart_unlocked();
        do_op(4'd1, 32'd12);
        @(negedge clk);
        bus.C_start = 1'b1;
        @(negedge clk);
        total++;
        if (bus.err !== 3'd3 || bus.state !== 3'd1) begin
            $display("FAIL cstart: err=%0d state=%0d need 3/1",
                     bus.err, bus.state);
            bad++;
        end
        do_op(4'd8, 32'd9);
        bus.C_start = 1'b0;
        total++;
        if (bus.err !== 3'd0 || bus.bidCharge !== 32'd9) begin
            $display("FAIL op_prio: err=%0d charge=%0d need 0/9",
                     bus.err, bus.bidCharge);
            bad++;
        end
        do_op(4'd7, 32'd0);
        total++;
        if (bus.timer !== 32'd1) begin
            $display("FAIL timer0: got %0d need 1", bus.timer);
            bad++;
        end
        do_op(4'd7, 32'd20);
    endtask

    task automatic test_invalid_op();
        do_op(4'd12, 32'd0);
        total++;
        if (bus.err !== 3'd4 || bus.state !== 3'd1) begin
            $display("FAIL inv_unl: err=%0d state=%0d need 4/1",
                     bus.err, bus.state);
            bad++;
        end
        do_op(4'd2, 32'd12);
        do_op(4'd3, 32'd99);
        total++;
        if (bus.err !== 3'd4 || bus.bidderValue[31:0] !== 32'd45) begin
            $display("FAIL inv_lck: err=%0d x=%0d need 4/45",
                     bus.err, bus.bidderValue[31:0]);
            bad++;
        end
        do_op(4'd1, 32'd12);
        do_op(4'd2, 32'd7);
        total++;
        if (bus.err !== 3'd0) begin
            $display("FAIL inv_clr: err=%0d need 0", bus.err);
            bad++;
        end
        @(negedge clk);
        total++;
        if (bus.err !== 3'd0 || bus.state !== 3'd3) begin
            $display("FAIL noop_hold: err=%0d state=%0d need 0/3",
                     bus.err, bus.state);
            bad++;
        end
    endtask

    task automatic test_async_reset();
        do_op(4'd6, 32'd0);
        @(negedge clk);
        bus.C_start = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.state !== 3'd4 || bus.err !== 3'd4) begin
            $display("FAIL pre_rst: state=%0d err=%0d need 4/4",
                     bus.state, bus.err);
            bad++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.state !== 3'd0 || bus.roundActive !== 1'b0 ||
            bus.ready !== 1'b0 || bus.err !== 3'd0) begin
            $display("FAIL arst_st: st=%0d ra=%0b rdy=%0b err=%0d need 0",
                     bus.state, bus.roundActive, bus.ready, bus.err);
            bad++;
        end
        total++;
        if (bus.timer !== 32'd15 || bus.mask !== 3'b111 ||
            bus.bidCharge !== 32'd1 || bus.bidderValue !== 96'd0) begin
            $display("FAIL arst_cfg: t=%0d m=%b c=%0d need 15/111/1",
                     bus.timer, bus.mask, bus.bidCharge);
            bad++;
        end
        bus.C_start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.state !== 3'd1 || bus.ready !== 1'b1) begin
            $display("FAIL arst_rel: state=%0d ready=%0b need 1/1",
                     bus.state, bus.ready);
            bad++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_load();
        test_lock_unlock();
        test_badkey();
        test_round();
        test_timer_expiry();
        test_cstart_unlocked();
        test_invalid_op();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bids22_ctrl_responder.md
Name: bids22_ctrl_responder

Overview:
- Responder end of the bids22 control port: consumes C_op/C_data/C_start from the bench/host and owns the lock FSM.
- Owns the configuration registers: bidder values, mask, timer and bid charge.
- Produces ready, err and round sequencing (roundActive, roundOver) for the bid arbitration datapath, which reads the config outputs directly.
- Does not evaluate bids; maxBid is outside this block.

Parameters:
- DATAWIDTH, 32, width of C_data and all value/key/timer registers.
- NUMBIDDERS, 3, number of bidders; width of mask.
- COOLDOWN_CYCLES, 8, cycles spent in COOLDOWN after a bad unlock key.
- TIMER_RESET, 15, reset value of the round timer register.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- C_data  in  DATAWIDTH  operand for C_op.
- C_op  in  4  opcode: 0 NO_OP, 1 UNLOCK, 2 LOCK, 3 LOADX, 4 LOADY, 5 LOADZ, 6 SETMASK, 7 SETTIMER, 8 SETBIDCHARGE; 9-15 are invalid.
- C_start  in  1  round request, level-held by the host.
- ready  out  1  block will accept C_op this cycle.
- err  out  3  outerrors_t: 0 NOERROR, 1 BADKEY, 2 ALREADYUNLOCKED, 3 CSTARTWHENUNLOCKED, 4 INVALID_OP.
- roundOver  out  1  one-cycle pulse when a round ends.
- roundActive  out  1  high in ROUNDSTARTED.
- state  out  3  states_t encoding: 0 RESET, 1 UNLOCKED, 2 COOLDOWN, 3 LOCKED, 4 ROUNDSTARTED, 5 ROUNDOVER, 6 READYNEXT.
- bidderValue  out  NUMBIDDERS*DATAWIDTH  loaded values; slice 0 = X, 1 = Y, 2 = Z.
- mask  out  NUMBIDDERS  bidder enable mask.
- timer  out  DATAWIDTH  round length limit in cycles.
- bidCharge  out  DATAWIDTH  per-bid charge.

Behaviour:
- Reset (async assert, sync release):
  - state=RESET, ready=0, err=NOERROR, roundOver=0, roundActive=0.
  - values=0, mask all 1s, timer=TIMER_RESET, bidCharge=1, key=0, counters=0.
  - First posedge after reset_n=1: RESET->UNLOCKED.
  - reset_n low in any state, including mid-round or mid-cooldown, returns to the full reset state immediately.
- ready=1 only in UNLOCKED and LOCKED. C_op is sampled only when ready=1; otherwise it is ignored and err holds.
- err is registered.
  - Updated at the posedge that samples a non-NO_OP op while ready=1: set to the error code, or NOERROR on success.
  - Holds otherwise; NO_OP never changes it.
- UNLOCKED:
  - LOADX/LOADY/LOADZ write bidderValue slice 0/1/2 with C_data.
  - SETMASK writes mask=C_data[NUMBIDDERS-1:0].
  - SETTIMER writes timer=C_data; a value of 0 is stored as 1.
  - SETBIDCHARGE writes bidCharge=C_data.
  - LOCK stores key=C_data and goes to LOCKED.
  - UNLOCK leaves state unchanged, err=ALREADYUNLOCKED.
  - Opcodes 9-15: err=INVALID_OP.
  - C_start=1 sampled with C_op=NO_OP: err=CSTARTWHENUNLOCKED, no state change.
  - If both a non-NO_OP op and C_start=1 are present, the op takes priority.
- LOCKED:
  - UNLOCK with C_data==key goes to UNLOCKED.
  - UNLOCK with mismatched key: err=BADKEY, go to COOLDOWN.
  - LOCK and LOAD*/SET* ops: err=INVALID_OP, registers unchanged.
  - A C_start rising edge (C_start=1, previous-cycle C_start=0) with C_op=NO_OP goes to ROUNDSTARTED and clears the round counter.
  - A C_start held high from before entering LOCKED does not start a round.
- COOLDOWN:
  - Counts COOLDOWN_CYCLES posedges, then returns to LOCKED. All ops are ignored.
- ROUNDSTARTED:
  - roundActive=1; the round counter increments each cycle.
  - Exits to ROUNDOVER when C_start=0, or when counter+1==timer (expiry), whichever comes first.
  - A round lasts at most timer cycles.
- ROUNDOVER: roundOver=1 for exactly one cycle, then READYNEXT.
- READYNEXT: one cycle, then LOCKED. The next round requires a fresh C_start rising edge.
- Register writes are visible on outputs the cycle after the sampling posedge (1-cycle latency).

Test Plan:
- Reset release, idle -> cycle 1: state=UNLOCKED, ready=1, timer=15, bidCharge=1, mask=3'b111.
- LOADX 45, LOADY 46, LOADZ 47, SETMASK 3'b101 -> bidderValue slices = 45/46/47, mask=101, err=NOERROR throughout.
- LOCK 12; UNLOCK 12 -> state LOCKED then UNLOCKED. Then UNLOCK 12 again -> err=ALREADYUNLOCKED.
- LOCK 12; UNLOCK 13 -> err=BADKEY, ready=0 for 8 cycles (COOLDOWN), then LOCKED, ready=1. UNLOCK 12 -> UNLOCKED, err=NOERROR.
- LOCK; hold C_start 3 cycles -> ROUNDSTARTED 3 cycles, single roundOver pulse, READYNEXT, LOCKED. With SETTIMER 4 and C_start held 10 cycles -> round ends after 4 cycles, and no second round starts until C_start drops and rises again.
- Unlocked C_start=1 -> err=CSTARTWHENUNLOCKED. Opcode 12 -> INVALID_OP. reset_n low mid-round -> all outputs return to reset values asynchronously.
